// File: rtl/masked_lin_map_pipe.sv
`default_nettype none
// ============================================================================
// Module      : masked_lin_map_pipe
// Description : Share-wise GF(2) basis-change map (AES <-> tower) for a
//               DOM-masked S-box, behind a PIPE-deep valid/ready pipeline.
// Revision    : 1.0  initial release
// ============================================================================
module masked_lin_map_pipe #(
    parameter int N    = 2,
    parameter int PIPE = 1
) (
    input  logic             ClkxCI,
    input  logic             RstxRI,
    input  logic             ModexSI,
    input  logic             InValidxSI,
    output logic             InReadyxSO,
    input  logic [8*N-1:0]   DataInxDI,
    output logic             OutValidxSO,
    input  logic             OutReadyxSI,
    output logic [8*N-1:0]   DataOutxDO,
    output logic             ModexSO,
    output logic             BusyxSO
);

    localparam int c_WIDTH = 8 * N;

    // AES basis -> tower basis
    function automatic logic [7:0] f_inMap(input logic [7:0] x);
        f_inMap = {x[7] ^ x[6] ^ x[5] ^ x[2] ^ x[1] ^ x[0],
                   x[6] ^ x[5] ^ x[4] ^ x[0],
                   x[6] ^ x[5] ^ x[1] ^ x[0],
                   x[7] ^ x[6] ^ x[5] ^ x[0],
                   x[7] ^ x[4] ^ x[3] ^ x[1] ^ x[0],
                   x[0],
                   x[6] ^ x[5] ^ x[0],
                   x[6] ^ x[3] ^ x[2] ^ x[1] ^ x[0]};
    endfunction

    // tower basis -> AES basis
    function automatic logic [7:0] f_outMap(input logic [7:0] x);
        f_outMap = {x[5] ^ x[3],
                    x[7] ^ x[3],
                    x[6] ^ x[0],
                    x[7] ^ x[5] ^ x[3],
                    x[7] ^ x[6] ^ x[5] ^ x[4] ^ x[3],
                    x[6] ^ x[5] ^ x[3] ^ x[2] ^ x[0],
                    x[5] ^ x[4] ^ x[1],
                    x[6] ^ x[4] ^ x[1]};
    endfunction

    logic [c_WIDTH-1:0] w_mapped;
    logic [PIPE:0]      w_canLoad;
    logic [PIPE-1:0]    r_valid;
    logic [PIPE-1:0]    r_mode;
    logic [c_WIDTH-1:0] r_data [PIPE];

    generate
        for (genvar i = 0; i < N; i++) begin : g_share
            assign w_mapped[8*i +: 8] = ModexSI ? f_inMap(DataInxDI[8*i +: 8])
                                                : f_outMap(DataInxDI[8*i +: 8]);
        end
    endgenerate

    // A stage may load if it is empty or its occupant moves on this cycle.
    always_comb begin
        w_canLoad       = '0;
        w_canLoad[PIPE] = OutReadyxSI;
        for (int k = PIPE - 1; k >= 0; k--) begin
            w_canLoad[k] = ~r_valid[k] | w_canLoad[k+1];
        end
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_valid <= '0;
            r_mode  <= '0;
            for (int k = 0; k < PIPE; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            if (w_canLoad[0]) begin
                r_valid[0] <= InValidxSI;
                if (InValidxSI) begin
                    r_data[0] <= w_mapped;
                    r_mode[0] <= ModexSI;
                end
            end
            // Data/mode only move with a real beat so shares never toggle on bubbles.
            for (int k = 1; k < PIPE; k++) begin
                if (w_canLoad[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_data[k] <= r_data[k-1];
                        r_mode[k] <= r_mode[k-1];
                    end
                end
            end
        end
    end

    assign InReadyxSO  = w_canLoad[0];
    assign OutValidxSO = r_valid[PIPE-1];
    assign DataOutxDO  = r_data[PIPE-1];
    assign ModexSO     = r_mode[PIPE-1];
    assign BusyxSO     = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_masked_lin_map_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_masked_lin_map_pipe
// Description : Self-checking bench: directed and random traffic against a
//               matrix-row reference map and an in-order scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_masked_lin_map_pipe;

    localparam int NA = 2;
    localparam int PA = 1;
    localparam int NB = 3;
    localparam int PB = 3;
    localparam int WA = 8 * NA;
    localparam int WB = 8 * NB;

    // Row b = set of input bits XORed into output bit b.
    localparam logic [7:0] ROW_IN  [8] = '{8'h4F, 8'h61, 8'h01, 8'h9B, 8'hE1, 8'h63, 8'h71, 8'hE7};
    localparam logic [7:0] ROW_OUT [8] = '{8'h52, 8'h32, 8'h6D, 8'hF8, 8'hA8, 8'h41, 8'h88, 8'h28};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          aModeIn, aInValid, aInReady, aOutValid, aOutReady, aModeOut, aBusy;
    logic [WA-1:0] aDataIn, aDataOut;
    logic          bModeIn, bInValid, bInReady, bOutValid, bOutReady, bModeOut, bBusy;
    logic [WB-1:0] bDataIn, bDataOut;

    masked_lin_map_pipe #(.N(NA), .PIPE(PA)) u_dutA (
        .ClkxCI(clk), .RstxRI(rst), .ModexSI(aModeIn), .InValidxSI(aInValid),
        .InReadyxSO(aInReady), .DataInxDI(aDataIn), .OutValidxSO(aOutValid),
        .OutReadyxSI(aOutReady), .DataOutxDO(aDataOut), .ModexSO(aModeOut), .BusyxSO(aBusy));

    masked_lin_map_pipe #(.N(NB), .PIPE(PB)) u_dutB (
        .ClkxCI(clk), .RstxRI(rst), .ModexSI(bModeIn), .InValidxSI(bInValid),
        .InReadyxSO(bInReady), .DataInxDI(bDataIn), .OutValidxSO(bOutValid),
        .OutReadyxSI(bOutReady), .DataOutxDO(bDataOut), .ModexSO(bModeOut), .BusyxSO(bBusy));

    int errCount = 0;
    int chkCount = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] refMap(input logic [7:0] x, input logic mode);
        logic [7:0] y;
        y = '0;
        for (int b = 0; b < 8; b++) y[b] = ^(x & (mode ? ROW_IN[b] : ROW_OUT[b]));
        return y;
    endfunction

    function automatic logic [WA-1:0] refA(input logic [WA-1:0] d, input logic mode);
        return {refMap(d[15:8], mode), refMap(d[7:0], mode)};
    endfunction

    function automatic logic [WB-1:0] refB(input logic [WB-1:0] d, input logic mode);
        logic [WB-1:0] r;
        r = '0;
        for (int s = 0; s < NB; s++) r[8*s +: 8] = refMap(d[8*s +: 8], mode);
        return r;
    endfunction

    // Scoreboard for DUT B: sampled at negedge, inputs only change just after posedge.
    logic [WB:0]   sbQ [$];
    logic [WB:0]   sbExp;
    logic          sbHold = 1'b0;
    logic [WB-1:0] sbHoldData;
    logic          sbHoldMode;
    int            bAccCnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            sbQ.delete();
            sbHold = 1'b0;
        end else begin
            if (sbHold) begin
                checkEq("sb stall valid", 32'(bOutValid), 32'd1);
                checkEq("sb stall data", 32'(bDataOut), 32'(sbHoldData));
                checkEq("sb stall mode", 32'(bModeOut), 32'(sbHoldMode));
            end
            if (bInValid && bInReady) begin
                sbQ.push_back({bModeIn, bDataIn});
                bAccCnt++;
            end
            if (bOutValid && bOutReady) begin
                if (sbQ.size() == 0) begin
                    checkEq("sb extra beat", 32'(bOutValid), 32'd0);
                end else begin
                    sbExp = sbQ.pop_front();
                    checkEq("sb data", 32'(bDataOut), 32'(refB(sbExp[WB-1:0], sbExp[WB])));
                    checkEq("sb mode", 32'(bModeOut), 32'(sbExp[WB]));
                end
            end
            sbHold     = bOutValid && !bOutReady;
            sbHoldData = bDataOut;
            sbHoldMode = bModeOut;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drainB(input string tag);
        bInValid  = 1'b0;
        bOutReady = 1'b1;
        for (int i = 0; i < 20 && (sbQ.size() != 0 || bBusy); i++) nextCycle();
        checkEq(tag, 32'(sbQ.size()), 32'd0);
        checkEq(tag, 32'(bBusy), 32'd0);
    endtask

    int firstAcc, firstOut, lastOut, outCnt, gaps, sent, accStart;

    initial begin
        rst = 1'b1;
        aModeIn = 0; aInValid = 0; aOutReady = 0; aDataIn = '0;
        bModeIn = 0; bInValid = 0; bOutReady = 0; bDataIn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEq("rst A valid", 32'(aOutValid), 32'd0);
        checkEq("rst A data", 32'(aDataOut), 32'd0);
        checkEq("rst A busy", 32'(aBusy), 32'd0);
        checkEq("rst A inReady", 32'(aInReady), 32'd1);
        checkEq("rst B valid", 32'(bOutValid), 32'd0);
        checkEq("rst B data", 32'(bDataOut), 32'd0);
        checkEq("rst B mode", 32'(bModeOut), 32'd0);
        checkEq("rst B inReady", 32'(bInReady), 32'd1);
        nextCycle();
        rst = 1'b0;

        // DUT A: known vectors, latency 1
        aOutReady = 1; aInValid = 1; aModeIn = 1; aDataIn = 16'h0001;
        @(negedge clk);
        checkEq("t1 inReady", 32'(aInReady), 32'd1);
        checkEq("t1 no early valid", 32'(aOutValid), 32'd0);
        nextCycle();
        aDataIn = 16'h0080;
        @(negedge clk);
        checkEq("t1 valid", 32'(aOutValid), 32'd1);
        checkEq("t1 data 01", 32'(aDataOut), 32'h00FF);
        checkEq("t1 mode", 32'(aModeOut), 32'd1);
        nextCycle();
        aModeIn = 0; aDataIn = 16'h0108;
        @(negedge clk);
        checkEq("t1 data 80", 32'(aDataOut), 32'h0098);
        nextCycle();
        aInValid = 0; aDataIn = 16'hFFFF;
        @(negedge clk);
        checkEq("t2 data", 32'(aDataOut), 32'h24DC);
        checkEq("t2 mode", 32'(aModeOut), 32'd0);
        checkEq("t2 unmasked", 32'(aDataOut[15:8] ^ aDataOut[7:0]), 32'h00F8);
        nextCycle();
        @(negedge clk);
        checkEq("t2 drained valid", 32'(aOutValid), 32'd0);
        checkEq("t2 bubble hold", 32'(aDataOut), 32'h24DC);
        checkEq("t2 busy", 32'(aBusy), 32'd0);

        // DUT A: stall and release
        nextCycle();
        aOutReady = 0; aInValid = 1; aModeIn = 1; aDataIn = 16'h5502;
        @(negedge clk);
        checkEq("tA stall inReady empty", 32'(aInReady), 32'd1);
        nextCycle();
        aModeIn = 0; aDataIn = 16'h3304;
        @(negedge clk);
        checkEq("tA full inReady", 32'(aInReady), 32'd0);
        checkEq("tA full data", 32'(aDataOut), 32'(refA(16'h5502, 1'b1)));
        nextCycle();
        @(negedge clk);
        checkEq("tA hold data", 32'(aDataOut), 32'(refA(16'h5502, 1'b1)));
        checkEq("tA hold valid", 32'(aOutValid), 32'd1);
        nextCycle();
        aOutReady = 1;
        @(negedge clk);
        checkEq("tA release inReady", 32'(aInReady), 32'd1);
        nextCycle();
        aInValid = 0;
        @(negedge clk);
        checkEq("tA next data", 32'(aDataOut), 32'(refA(16'h3304, 1'b0)));
        checkEq("tA next mode", 32'(aModeOut), 32'd0);
        checkEq("tA next valid", 32'(aOutValid), 32'd1);
        nextCycle();
        @(negedge clk);
        checkEq("tA empty valid", 32'(aOutValid), 32'd0);
        nextCycle();

        // DUT B: 16-beat stream, alternating mode
        bOutReady = 1;
        firstAcc = -1; firstOut = -1; lastOut = -1; outCnt = 0; gaps = 0; sent = 0;
        for (int c = 0; c < 40; c++) begin
            if (sent < 16) begin
                bInValid = 1; bModeIn = sent[0]; bDataIn = 24'($urandom);
            end else begin
                bInValid = 0;
            end
            @(negedge clk);
            if (bInValid && bInReady) begin
                if (firstAcc < 0) firstAcc = cyc;
                sent++;
            end
            if (bOutValid) begin
                if (firstOut < 0) firstOut = cyc;
                else if (cyc != lastOut + 1) gaps++;
                lastOut = cyc;
                outCnt++;
            end
            nextCycle();
        end
        checkEq("t3 latency", 32'(firstOut - firstAcc), 32'd3);
        checkEq("t3 beats", 32'(outCnt), 32'd16);
        checkEq("t3 gaps", 32'(gaps), 32'd0);

        // DUT B: fill with OutReady low, then release
        bOutReady = 0; sent = 0;
        for (int c = 0; c < 10 && sent < 3; c++) begin
            bInValid = 1; bModeIn = 1'($urandom); bDataIn = 24'($urandom);
            @(negedge clk);
            if (bInValid && bInReady) sent++;
            nextCycle();
        end
        checkEq("t4 accepts", 32'(sent), 32'd3);
        bDataIn = 24'h123456; bModeIn = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkEq("t4 full inReady", 32'(bInReady), 32'd0);
            checkEq("t4 full valid", 32'(bOutValid), 32'd1);
            nextCycle();
        end
        bOutReady = 1;
        @(negedge clk);
        checkEq("t4 release inReady", 32'(bInReady), 32'd1);
        nextCycle();
        bInValid = 0;
        @(negedge clk);
        checkEq("t4 occupancy kept", 32'(bOutValid), 32'd1);
        nextCycle();
        drainB("t4 drain");

        // DUT B: random traffic
        accStart = bAccCnt;
        for (int c = 0; c < 60000 && (bAccCnt - accStart) < 10000; c++) begin
            bInValid  = ($urandom_range(0, 3) != 0);
            bModeIn   = 1'($urandom);
            bDataIn   = 24'($urandom);
            bOutReady = ($urandom_range(0, 3) != 0);
            nextCycle();
        end
        checkEq("t5 beat budget", 32'((bAccCnt - accStart) >= 10000), 32'd1);
        drainB("t5 drain");

        // DUT B: reset with beats in flight
        bOutReady = 0; sent = 0;
        for (int c = 0; c < 5 && sent < 2; c++) begin
            bInValid = 1; bModeIn = 1; bDataIn = 24'hA5A5A5;
            @(negedge clk);
            if (bInValid && bInReady) sent++;
            nextCycle();
        end
        bInValid = 0;
        @(negedge clk);
        checkEq("t6 busy before", 32'(bBusy), 32'd1);
        nextCycle();
        rst = 1; bOutReady = 1;
        nextCycle();
        rst = 0;
        @(negedge clk);
        checkEq("t6 valid", 32'(bOutValid), 32'd0);
        checkEq("t6 busy", 32'(bBusy), 32'd0);
        checkEq("t6 data", 32'(bDataOut), 32'd0);
        checkEq("t6 mode", 32'(bModeOut), 32'd0);
        checkEq("t6 inReady", 32'(bInReady), 32'd1);
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            @(negedge clk);
            checkEq("t6 no stale", 32'(bOutValid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

endmodule
`default_nettype wire
